// File: rtl/i2c_slave_regfile.sv
// Eight-entry byte register file behind an I2C slave byte interface: the first byte after
// START sets the pointer, later bytes write through it, transmit requests read through it.
module i2c_slave_regfile #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       start_det,
  input  logic       stop_det,
  input  logic       tx_req,
  output logic [7:0] tx_data,
  input  logic [2:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_pulse,
  output logic [2:0] wr_addr,
  output logic       addr_err,
  input  logic       clr_err
);

  typedef enum logic [1:0] {StIdle, StPtr, StData} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic       err_q, err_d;
  logic [7:0] regs_q [8];
  logic [7:0] tx_data_q, host_rdata_q;
  logic       wr_pulse_q;
  logic [2:0] wr_addr_q;

  logic rx_take, tx_take, ptr_load, data_wr;

  always_comb begin
    // START drops a coincident byte; a received byte pre-empts a coincident tx request.
    rx_take  = rx_valid & ~start_det & (state_q != StIdle);
    tx_take  = tx_req & ~rx_valid;
    ptr_load = rx_take & (state_q == StPtr);
    data_wr  = rx_take & (state_q == StData);

    ptr_d = ptr_q;
    if (ptr_load) begin
      ptr_d = rx_data[2:0];
    end else if (data_wr || tx_take) begin
      ptr_d = ptr_q + 3'd1;
    end

    err_d = (ptr_load & (|rx_data[7:3])) | (err_q & ~clr_err);

    state_d = state_q;
    if (start_det) begin
      state_d = StPtr;
    end else if (stop_det) begin
      state_d = StIdle;
    end else if (ptr_load || (tx_take && state_q == StPtr)) begin
      state_d = StData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= 3'd0;
      err_q        <= 1'b0;
      tx_data_q    <= 8'h00;
      host_rdata_q <= 8'h00;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      err_q        <= err_d;
      wr_pulse_q   <= data_wr;
      host_rdata_q <= regs_q[host_addr];
      if (data_wr) begin
        regs_q[ptr_q] <= rx_data;
        wr_addr_q     <= ptr_q;
      end
      if (tx_take) begin
        tx_data_q <= regs_q[ptr_q];
      end
    end
  end

  assign tx_data    = tx_data_q;
  assign host_rdata = host_rdata_q;
  assign wr_pulse   = wr_pulse_q;
  assign wr_addr    = wr_addr_q;
  assign addr_err   = err_q;

endmodule
